axi_lite_single_master: RTL
===========================

# axi_lite_single_master

Single-outstanding AXI4-Lite initiator that turns one-shot register commands from local control logic into AXI-Lite read or write transactions and returns the response. It drives the slave port of the on-chip register blocks (e.g. the ASIC function interface registers at offsets 0x0/0x4/0x8), letting hardware sequencers access them without the PS.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 supported.
- C_M_AXI_ADDR_WIDTH, 9, address width.
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks; used only with the timeout feature; must be ≥ 2.

Ports:
- M_AXI_ACLK  in  1  single clock; all logic on rising edge.
- M_AXI_ARESET  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data (0 for writes).
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response produced by watchdog.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths; AWPROT/ARPROT driven 3'b000.

## Operation
- States: IDLE, WRITE (AW+W in flight), WRESP, READ (AR in flight), RRESP, DONE.
- IDLE: cmd_ready=1; on cmd_valid capture addr/data/strb/dir → WRITE or READ.
- WRITE: AWVALID and WVALID asserted together, each dropped independently in the cycle after its own handshake; BREADY=1. B may be accepted in the same cycle as the last AW/W handshake (slave may present BVALID early); go to DONE when B accepted, else to WRESP once both AW and W are done.
- WRESP: BREADY=1; on BVALID capture BRESP → DONE.
- READ: ARVALID=1, RREADY=1; R accepted in same cycle as AR handshake or later. AR done and no R → RRESP.
- RRESP: RREADY=1; on RVALID capture RDATA/RRESP → DONE.
- DONE: rsp_valid=1, all AXI valids/readies 0; rsp_ready → IDLE. New command accepted no earlier than the cycle after rsp is consumed.
- cmd_valid outside IDLE ignored (cmd_ready=0). Captured command unaffected by cmd_* changes.
- Addresses/data driven from capture registers; stable while VALID high.

## Timing
- Reset (async assert): state IDLE; all AXI VALID/READY 0; AWADDR/ARADDR/WDATA/WSTRB 0; cmd_ready 0 during reset, 1 first cycle after release; rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_timeout 0.
- Reset mid-transaction: abort immediately; no response issued.
- Latency: cmd accepted at edge N → AWVALID/WVALID or ARVALID high after edge N; with a zero-wait slave responding one cycle later, rsp_valid high 3 cycles after acceptance.
- All outputs registered except cmd_ready (decoded from state register).

## Configuration
- AXI_MASTER_TIMEOUT_EN defined: counter cleared in IDLE, increments each cycle in WRITE/WRESP/READ/RRESP; reaching TIMEOUT_CYCLES drops all AXI valids/readies, enters DONE with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0. A handshake completing in the timeout cycle wins (normal response).
- Not defined: no counter; master waits indefinitely; rsp_timeout tied 0.

## Test plan
- Write 0x0000_00A5 strb 4'hF to 0x004, slave ready 1 cycle after valid, BRESP 00 → one AW and one W handshake, rsp_valid with rsp_resp 00, rsp_rdata 0.
- Read 0x008 returning 0x1234_5678, RVALID with ARREADY same cycle → rsp_rdata 0x1234_5678, rsp_resp 00, exactly one R beat.
- Write with AWREADY 3 cycles before WREADY, BVALID in WREADY cycle → AWVALID drops alone, B accepted same cycle, single response.
- cmd_valid held high through a read and rsp_ready low 5 cycles → second command only accepted after rsp consumed; rsp_valid/rsp_rdata stable all 5 cycles.
- With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never responds → at cycle 16 valids drop, rsp_resp 2'b10, rsp_timeout 1.
- M_AXI_ARESET pulsed while ARVALID high → ARVALID 0 immediately, no rsp_valid, next read completes normally.

Source files
------------

// File: rtl/axi_lite_single_master.sv
// Single-outstanding AXI4-Lite master: one local register command in, one response out.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module axi_lite_single_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_WRESP, ST_READ, ST_RRESP, ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic awvalid_reg, awvalid_next, wvalid_reg, wvalid_next, bready_reg, bready_next;
  logic arvalid_reg, arvalid_next, rready_reg, rready_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_reg, wstrb_next;
  logic                            rsp_valid_reg, rsp_valid_next;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]                      rsp_resp_reg, rsp_resp_next;
  logic                            rsp_timeout_reg, rsp_timeout_next;

  logic b_hs, r_hs, ar_hs, aw_pending, w_pending, timeout_hit;

  assign b_hs       = bready_reg && M_AXI_BVALID;
  assign r_hs       = rready_reg && M_AXI_RVALID;
  assign ar_hs      = arvalid_reg && M_AXI_ARREADY;
  assign aw_pending = awvalid_reg && !M_AXI_AWREADY;
  assign w_pending  = wvalid_reg && !M_AXI_WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TimerW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TimerW-1:0] timer_reg;
  logic              busy;

  assign busy = (state_reg == ST_WRITE) || (state_reg == ST_WRESP) ||
                (state_reg == ST_READ)  || (state_reg == ST_RRESP);

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET)  timer_reg <= '0;
    else if (busy)     timer_reg <= timer_reg + 1'b1;
    else               timer_reg <= '0;
  end

  // Fires on the edge where the count would reach TIMEOUT_CYCLES.
  assign timeout_hit = busy && (timer_reg == TimerW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state_reg <= ST_IDLE;
    else              state_reg <= state_next;
  end

  // Completing handshakes take priority over the watchdog in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (cmd_valid) state_next = cmd_write ? ST_WRITE : ST_READ;
      ST_WRITE: if (b_hs || timeout_hit)        state_next = ST_DONE;
                else if (!aw_pending && !w_pending) state_next = ST_WRESP;
      ST_WRESP: if (b_hs || timeout_hit)        state_next = ST_DONE;
      ST_READ:  if (r_hs || timeout_hit)        state_next = ST_DONE;
                else if (ar_hs)                 state_next = ST_RRESP;
      ST_RRESP: if (r_hs || timeout_hit)        state_next = ST_DONE;
      ST_DONE:  if (rsp_ready)                  state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid_next     = awvalid_reg;
    wvalid_next      = wvalid_reg;
    bready_next      = bready_reg;
    arvalid_next     = arvalid_reg;
    rready_next      = rready_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    wstrb_next       = wstrb_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_resp_next    = rsp_resp_reg;
    rsp_timeout_next = rsp_timeout_reg;
    case (state_reg)
      ST_IDLE: if (cmd_valid) begin
        addr_next    = cmd_addr;
        wdata_next   = cmd_wdata;
        wstrb_next   = cmd_wstrb;
        awvalid_next = cmd_write;
        wvalid_next  = cmd_write;
        bready_next  = cmd_write;
        arvalid_next = !cmd_write;
        rready_next  = !cmd_write;
      end
      ST_WRITE, ST_WRESP: begin
        awvalid_next = aw_pending;
        wvalid_next  = w_pending;
      end
      ST_READ, ST_RRESP: arvalid_next = arvalid_reg && !M_AXI_ARREADY;
      ST_DONE: if (rsp_ready) rsp_valid_next = 1'b0;
      default: ;
    endcase
    if (state_reg != ST_DONE && state_next == ST_DONE) begin
      awvalid_next   = 1'b0;
      wvalid_next    = 1'b0;
      bready_next    = 1'b0;
      arvalid_next   = 1'b0;
      rready_next    = 1'b0;
      rsp_valid_next = 1'b1;
      if (b_hs) begin
        rsp_rdata_next   = '0;
        rsp_resp_next    = M_AXI_BRESP;
        rsp_timeout_next = 1'b0;
      end else if (r_hs) begin
        rsp_rdata_next   = M_AXI_RDATA;
        rsp_resp_next    = M_AXI_RRESP;
        rsp_timeout_next = 1'b0;
      end else begin
        rsp_rdata_next   = '0;
        rsp_resp_next    = 2'b10;
        rsp_timeout_next = 1'b1;
      end
    end
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      awvalid_reg     <= 1'b0;
      wvalid_reg      <= 1'b0;
      bready_reg      <= 1'b0;
      arvalid_reg     <= 1'b0;
      rready_reg      <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= 2'b00;
      rsp_timeout_reg <= 1'b0;
    end else begin
      awvalid_reg     <= awvalid_next;
      wvalid_reg      <= wvalid_next;
      bready_reg      <= bready_next;
      arvalid_reg     <= arvalid_next;
      rready_reg      <= rready_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      wstrb_reg       <= wstrb_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_resp_reg    <= rsp_resp_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  // cmd_ready is the only combinational output; it is held low while reset is asserted.
  assign cmd_ready     = (state_reg == ST_IDLE) && !M_AXI_ARESET;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_resp      = rsp_resp_reg;
  assign rsp_timeout   = rsp_timeout_reg;
  assign M_AXI_AWADDR  = addr_reg;
  assign M_AXI_ARADDR  = addr_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = wstrb_reg;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

endmodule
